// File: rtl/perceptron_pkg.sv
// ============================================================
// perceptron_pkg: shared types and constants for perceptron training control
// Revision 1.0
// ============================================================
`default_nettype none

package perceptron_pkg;

  localparam int DEF_N_SAMPLES_MAX = 4;
  localparam int DEF_INP_DIM       = 2;
  localparam int DEF_EPOCH_W       = 4;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_LATCH     = 3'd2,
    S_ISSUE     = 3'd3,
    S_WAIT_RSP  = 3'd4,
    S_UPDATE    = 3'd5,
    S_EPOCH_END = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  localparam logic signed [1:0] DELTA_POS = 2'sb01;
  localparam logic signed [1:0] DELTA_NEG = 2'sb11;

  // A mismatch means act == !y, so the error sign follows the label alone.
  function automatic logic signed [1:0] miss_delta(input logic y);
    return y ? DELTA_POS : DELTA_NEG;
  endfunction

endpackage

`default_nettype wire

// File: rtl/perceptron_train_ctrl.sv
// ============================================================
// perceptron_train_ctrl: sequences training epochs over the sample store
// Revision 1.0
// ============================================================
`default_nettype none

module perceptron_train_ctrl
  import perceptron_pkg::*;
#(
  parameter int N_SAMPLES_MAX = DEF_N_SAMPLES_MAX,
  parameter int INP_DIM       = DEF_INP_DIM,
  parameter int EPOCH_W       = DEF_EPOCH_W,
  localparam int AW = (N_SAMPLES_MAX > 1) ? $clog2(N_SAMPLES_MAX) : 1,
  localparam int XW = 8 * INP_DIM
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [AW:0]        n_samples,
  input  logic [EPOCH_W-1:0] max_epochs,
  output logic               smp_rd_en,
  output logic [AW-1:0]      smp_addr,
  input  logic [XW-1:0]      smp_x,
  input  logic               smp_y,
  output logic               mac_req_valid,
  input  logic               mac_req_ready,
  output logic [XW-1:0]      mac_x,
  input  logic               mac_rsp_valid,
  input  logic               mac_rsp_act,
  output logic               upd_valid,
  output logic [1:0]         upd_delta,
  output logic [XW-1:0]      upd_x,
  output logic               busy,
  output logic               done,
  output logic               converged,
  output logic [EPOCH_W-1:0] epoch_cnt,
  output logic [AW:0]        err_cnt
);

  state_t              state, state_nxt;
  logic [AW-1:0]       idx, last_idx;
  logic [EPOCH_W-1:0]  max_ep, epoch_r;
  logic [AW:0]         err_r;
  logic                conv_r;
  logic [XW-1:0]       x_lat;
  logic                y_lat;
  logic signed [1:0]   delta_r;

  logic [AW:0]         ns_eff;
  logic [EPOCH_W-1:0]  me_eff;
  logic                rsp_miss;
  logic                last_smp;
  logic [EPOCH_W:0]    epoch_inc;
  logic                ep_limit;

  always_comb begin
    if (n_samples == '0) begin
      ns_eff = (AW+1)'(1);
    end else if (n_samples > (AW+1)'(N_SAMPLES_MAX)) begin
      ns_eff = (AW+1)'(N_SAMPLES_MAX);
    end else begin
      ns_eff = n_samples;
    end
    me_eff = (max_epochs == '0) ? EPOCH_W'(1) : max_epochs;
  end

  assign rsp_miss  = mac_rsp_valid && (mac_rsp_act != y_lat);
  assign last_smp  = (idx == last_idx);
  // One bit wider so the limit compare cannot alias when epoch_r is all ones.
  assign epoch_inc = {1'b0, epoch_r} + (EPOCH_W+1)'(1);
  assign ep_limit  = (epoch_inc == {1'b0, max_ep});

  always_comb begin
    state_nxt     = state;
    smp_rd_en     = 1'b0;
    mac_req_valid = 1'b0;
    upd_valid     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        smp_rd_en = 1'b1;
        state_nxt = S_LATCH;
      end
      S_LATCH: state_nxt = S_ISSUE;
      S_ISSUE: begin
        mac_req_valid = 1'b1;
        if (mac_req_ready) state_nxt = S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        if (mac_rsp_valid) begin
          if (rsp_miss)      state_nxt = S_UPDATE;
          else if (last_smp) state_nxt = S_EPOCH_END;
          else               state_nxt = S_FETCH;
        end
      end
      S_UPDATE: begin
        upd_valid = 1'b1;
        state_nxt = last_smp ? S_EPOCH_END : S_FETCH;
      end
      S_EPOCH_END: state_nxt = ((err_r == '0) || ep_limit) ? S_DONE : S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      last_idx <= '0;
      max_ep   <= '0;
      epoch_r  <= '0;
      err_r    <= '0;
      conv_r   <= 1'b0;
      x_lat    <= '0;
      y_lat    <= 1'b0;
      delta_r  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            idx      <= '0;
            last_idx <= AW'(ns_eff - (AW+1)'(1));
            max_ep   <= me_eff;
            epoch_r  <= '0;
            err_r    <= '0;
            conv_r   <= 1'b0;
          end
        end
        S_LATCH: begin
          x_lat <= smp_x;
          y_lat <= smp_y;
        end
        S_WAIT_RSP: begin
          if (mac_rsp_valid) begin
            if (rsp_miss) begin
              delta_r <= miss_delta(y_lat);
              if (err_r != '1) err_r <= err_r + (AW+1)'(1);
            end else if (!last_smp) begin
              idx <= idx + AW'(1);
            end
          end
        end
        S_UPDATE: begin
          if (!last_smp) idx <= idx + AW'(1);
        end
        S_EPOCH_END: begin
          if (epoch_r != '1) epoch_r <= epoch_r + EPOCH_W'(1);
          if (err_r == '0) begin
            conv_r <= 1'b1;
          end else if (!ep_limit) begin
            idx   <= '0;
            err_r <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign smp_addr  = smp_rd_en     ? idx     : '0;
  assign mac_x     = mac_req_valid ? x_lat   : '0;
  assign upd_x     = upd_valid     ? x_lat   : '0;
  assign upd_delta = upd_valid     ? delta_r : 2'b00;
  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign done      = (state == S_DONE);
  assign converged = conv_r;
  assign epoch_cnt = epoch_r;
  assign err_cnt   = err_r;

endmodule

`default_nettype wire

// File: tb/tb_perceptron_train_ctrl.sv
// ============================================================
// tb_perceptron_train_ctrl: randomized scoreboard bench for the training sequencer
// Revision 1.0
// ============================================================
`default_nettype none

module tb_perceptron_train_ctrl;

  localparam int NS_MAX = 4;
  localparam int EW     = 4;
  localparam int AW     = 2;
  localparam int XW     = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   n_samples = '0;
  logic [EW-1:0] max_epochs = '0;
  logic          smp_rd_en;
  logic [AW-1:0] smp_addr;
  logic [XW-1:0] smp_x;
  logic          smp_y;
  logic          mac_req_valid;
  logic          mac_req_ready;
  logic [XW-1:0] mac_x;
  logic          mac_rsp_valid;
  logic          mac_rsp_act;
  logic          upd_valid;
  logic [1:0]    upd_delta;
  logic [XW-1:0] upd_x;
  logic          busy, done, converged;
  logic [EW-1:0] epoch_cnt;
  logic [AW:0]   err_cnt;

  perceptron_train_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples), .max_epochs(max_epochs),
    .smp_rd_en(smp_rd_en), .smp_addr(smp_addr), .smp_x(smp_x), .smp_y(smp_y),
    .mac_req_valid(mac_req_valid), .mac_req_ready(mac_req_ready), .mac_x(mac_x),
    .mac_rsp_valid(mac_rsp_valid), .mac_rsp_act(mac_rsp_act),
    .upd_valid(upd_valid), .upd_delta(upd_delta), .upd_x(upd_x),
    .busy(busy), .done(done), .converged(converged), .epoch_cnt(epoch_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [1:0]    d;
  } upd_t;

  int   checks = 0;
  int   errors = 0;
  logic [XW-1:0] x_mem [NS_MAX];
  logic          y_mem [NS_MAX];
  int   act_q [$];
  upd_t upd_q [$];
  int   exp_ep, exp_err;
  bit   exp_conv;

  int   stall_fixed = -1;
  int   rsp_delay_fixed = -1;
  bit   glitch_en = 1'b0;
  bit   force_rsp = 1'b0;
  bit   dp_pending = 1'b0;

  task automatic chk_eq(input string name, input longint actv, input longint expv);
    checks++;
    if (actv != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actv, expv);
    end
  endtask

  function automatic bit outs_zero();
    return !smp_rd_en && smp_addr == '0 && !mac_req_valid && mac_x == '0 && !upd_valid &&
           upd_delta == '0 && upd_x == '0 && !busy && !done && !converged &&
           epoch_cnt == '0 && err_cnt == '0;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Sample store and MAC datapath models; they drive at negedge+2.
  bit            rd_prev = 1'b0;
  logic [AW-1:0] addr_prev = '0;
  int            stall_left = 0;
  bit            req_seen = 1'b0;
  int            rsp_wait = 0;
  bit            cur_act = 1'b0;

  initial begin : drv
    mac_req_ready = 1'b0;
    mac_rsp_valid = 1'b0;
    mac_rsp_act   = 1'b0;
    smp_x         = '0;
    smp_y         = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rd_prev && !rst) begin
        smp_x = x_mem[addr_prev];
        smp_y = y_mem[addr_prev];
      end else begin
        smp_x = XW'($urandom);
        smp_y = 1'($urandom);
      end
      rd_prev   = smp_rd_en;
      addr_prev = smp_addr;
      mac_req_ready = 1'b0;
      mac_rsp_valid = force_rsp;
      mac_rsp_act   = force_rsp ? 1'b1 : 1'($urandom);
      if (rst) begin
        dp_pending = 1'b0;
        req_seen   = 1'b0;
      end else begin
        if (dp_pending) begin
          if (rsp_wait == 0) begin
            mac_rsp_valid = 1'b1;
            mac_rsp_act   = cur_act;
            dp_pending    = 1'b0;
          end else begin
            rsp_wait--;
          end
        end
        if (mac_req_valid) begin
          if (!req_seen) begin
            req_seen   = 1'b1;
            stall_left = (stall_fixed >= 0) ? stall_fixed : $urandom_range(0, 3);
          end
          if (stall_left > 0) begin
            stall_left--;
          end else begin
            mac_req_ready = 1'b1;
            req_seen      = 1'b0;
            if (act_q.size() == 0) begin
              chk_eq("extra_request", 1, 0);
              cur_act = 1'b0;
            end else begin
              cur_act = act_q.pop_front() != 0;
            end
            dp_pending = 1'b1;
            rsp_wait   = (rsp_delay_fixed >= 0) ? rsp_delay_fixed : $urandom_range(0, 2);
            // A response in the acceptance cycle must be ignored by the DUT.
            if (glitch_en && $urandom_range(0, 1) == 1) begin
              mac_rsp_valid = 1'b1;
              mac_rsp_act   = !cur_act;
            end
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every update strobe, checks request hold.
  bit            stalled = 1'b0;
  logic [XW-1:0] prev_x = '0;

  initial begin : mon
    upd_t e;
    forever begin
      @(negedge clk);
      #3;
      if (stalled && !rst) begin
        chk_eq("req_valid_hold", longint'(mac_req_valid), 1);
        chk_eq("req_x_hold", longint'(mac_x), longint'(prev_x));
      end
      stalled = mac_req_valid && !mac_req_ready && !rst;
      prev_x  = mac_x;
      if (upd_valid) begin
        if (upd_q.size() == 0) begin
          chk_eq("unexpected_upd", 1, 0);
        end else begin
          e = upd_q.pop_front();
          chk_eq("upd_delta", longint'(upd_delta), longint'(e.d));
          chk_eq("upd_x", longint'(upd_x), longint'(e.x));
        end
      end
    end
  end

  // Reference: plays whole epochs from the training rules and records the
  // activation the datapath must return for every request, in order.
  task automatic build_model(input int ns_in, input int me_in, input int mode);
    int ns, me, e, errs;
    bit a;
    upd_t u;
    ns = (ns_in == 0) ? 1 : ((ns_in > NS_MAX) ? NS_MAX : ns_in);
    me = (me_in == 0) ? 1 : me_in;
    e = 0;
    errs = 0;
    act_q.delete();
    upd_q.delete();
    while (1) begin
      errs = 0;
      for (int i = 0; i < ns; i++) begin
        case (mode)
          0:       a = y_mem[i];
          1:       a = (e < 2) ? 1'b0 : y_mem[i];
          2:       a = 1'b1;
          default: a = ($urandom_range(0, 3) == 0) ? !y_mem[i] : y_mem[i];
        endcase
        act_q.push_back(int'(a));
        if (a != y_mem[i]) begin
          errs++;
          u.x = x_mem[i];
          u.d = y_mem[i] ? 2'b01 : 2'b11;
          upd_q.push_back(u);
        end
      end
      e++;
      if (errs == 0) begin exp_conv = 1'b1; break; end
      if (e == me)   begin exp_conv = 1'b0; break; end
    end
    exp_ep  = e;
    exp_err = errs;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    act_q.delete();
    upd_q.delete();
  endtask

  task automatic run_train(input int ns_in, input int me_in, input int mode, input bit busy_poke);
    int cyc;
    build_model(ns_in, me_in, mode);
    n_samples  = (AW+1)'(ns_in);
    max_epochs = EW'(me_in);
    start = 1'b1;
    tick();
    start = 1'b0;
    n_samples  = (AW+1)'($urandom);
    max_epochs = EW'($urandom);
    if (busy_poke) begin
      repeat (3) tick();
      chk_eq("busy_before_poke", longint'(busy), 1);
      n_samples  = 3'd3;
      max_epochs = 4'd4;
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    cyc = 0;
    while (!done && cyc < 4000) begin
      tick();
      cyc++;
    end
    if (!done) begin
      chk_eq("done_timeout", 0, 1);
      do_reset();
      return;
    end
    chk_eq("epoch_cnt", longint'(epoch_cnt), exp_ep);
    chk_eq("err_cnt", longint'(err_cnt), exp_err);
    chk_eq("converged", longint'(converged), longint'(exp_conv));
    chk_eq("busy_in_done", longint'(busy), 0);
    chk_eq("requests_left", act_q.size(), 0);
    chk_eq("updates_left", upd_q.size(), 0);
    tick();
    chk_eq("done_hold", longint'(done), 1);
  endtask

  initial begin : stim
    int cyc;
    for (int i = 0; i < NS_MAX; i++) begin
      x_mem[i] = XW'(16'h1111 * (i + 1));
      y_mem[i] = 1'b0;
    end
    repeat (3) tick();
    chk_eq("reset_outputs_zero", longint'(outs_zero()), 1);
    rst = 1'b0;
    tick();
    chk_eq("idle_outputs_zero", longint'(outs_zero()), 1);

    y_mem[0] = 1'b0; y_mem[1] = 1'b1; y_mem[2] = 1'b1;
    run_train(3, 4, 0, 1'b0);
    run_train(3, 4, 1, 1'b0);
    run_train(3, 2, 2, 1'b0);

    stall_fixed = 5;
    run_train(3, 4, 0, 1'b0);
    stall_fixed = -1;

    // Abort from WAIT_RSP with a response arriving under reset.
    rsp_delay_fixed = 4;
    build_model(3, 4, 2);
    n_samples = 3'd3; max_epochs = 4'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!(dp_pending && !mac_req_valid && busy) && cyc < 200) begin
      tick();
      cyc++;
    end
    chk_eq("reached_wait_rsp", longint'(dp_pending && !mac_req_valid && busy), 1);
    rst = 1'b1;
    force_rsp = 1'b1;
    upd_q.delete();
    tick();
    chk_eq("abort_outputs_zero", longint'(outs_zero()), 1);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_eq("post_abort_zero", longint'(outs_zero()), 1);
    end
    force_rsp = 1'b0;
    rsp_delay_fixed = -1;
    act_q.delete();

    // Zero config with a start poke while busy.
    y_mem[0] = 1'b1;
    run_train(0, 0, 1, 1'b1);
    run_train(6, 3, 2, 1'b0);

    glitch_en = 1'b1;
    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < NS_MAX; i++) begin
        x_mem[i] = XW'($urandom);
        y_mem[i] = 1'($urandom);
      end
      run_train($urandom_range(0, 7), $urandom_range(0, 15), 3, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
